// File: rtl/imem_arbiter.sv
// Two-port (fetch/debug) arbiter in front of a single-cycle registered instruction memory.
// Optional: define IMEM_ARB_RR_EN for two-way round-robin instead of fixed debug priority.
module imem_arbiter #(
    parameter int unsigned DWIDTH   = 32,
    parameter int unsigned MEMDEPTH = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_req,
    input  logic [DWIDTH-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic              f_err,
    output logic [DWIDTH-1:0] f_rdata,
    input  logic              d_req,
    input  logic [DWIDTH-1:0] d_addr,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic              d_err,
    output logic [DWIDTH-1:0] d_rdata,
    output logic              mem_en,
    output logic [DWIDTH-1:0] mem_addr,
    input  logic [DWIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {OwnNone, OwnFetch, OwnDebug} owner_e;

    owner_e owner_q, owner_d;
    logic   err_q, err_d;
    logic   debug_first;
    logic   f_legal, d_legal;

    function automatic logic is_legal(input logic [DWIDTH-1:0] a);
        logic [DWIDTH-1:0] widx;
        widx = {2'b00, a[DWIDTH-1:2]};
        return (a[1:0] == 2'b00) && (widx < DWIDTH'(MEMDEPTH));
    endfunction

    assign f_legal = is_legal(f_addr);
    assign d_legal = is_legal(d_addr);

`ifdef IMEM_ARB_RR_EN
    // Set when fetch was the most recent grant; on conflict the other port wins.
    logic last_fetch_q, last_fetch_d;

    always_comb begin
        last_fetch_d = last_fetch_q;
        if (d_gnt) begin
            last_fetch_d = 1'b0;
        end else if (f_gnt) begin
            last_fetch_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_fetch_q <= 1'b1;
        end else begin
            last_fetch_q <= last_fetch_d;
        end
    end

    assign debug_first = last_fetch_q;
`else
    assign debug_first = 1'b1;
`endif

    always_comb begin
        f_gnt    = 1'b0;
        d_gnt    = 1'b0;
        mem_en   = 1'b0;
        mem_addr = '0;
        owner_d  = OwnNone;
        err_d    = 1'b0;
        if (!reset) begin
            if (d_req && (!f_req || debug_first)) begin
                d_gnt   = 1'b1;
                owner_d = OwnDebug;
                err_d   = !d_legal;
                if (d_legal) begin
                    mem_en   = 1'b1;
                    mem_addr = d_addr;
                end
            end else if (f_req) begin
                f_gnt   = 1'b1;
                owner_d = OwnFetch;
                err_d   = !f_legal;
                if (f_legal) begin
                    mem_en   = 1'b1;
                    mem_addr = f_addr;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q <= OwnNone;
            err_q   <= 1'b0;
        end else begin
            owner_q <= owner_d;
            err_q   <= err_d;
        end
    end

    // Responses are gated by reset so a grant followed by reset is never delivered.
    always_comb begin
        f_rvalid = !reset && (owner_q == OwnFetch);
        d_rvalid = !reset && (owner_q == OwnDebug);
        f_err    = f_rvalid && err_q;
        d_err    = d_rvalid && err_q;
        f_rdata  = (f_rvalid && !err_q) ? mem_rdata : '0;
        d_rdata  = (d_rvalid && !err_q) ? mem_rdata : '0;
    end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameter DWIDTH, default 32: data and address word width.
REQ-002 Parameter MEMDEPTH, default 1024: instruction memory depth in words; legal word index is 0..MEMDEPTH-1.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 f_req  input  1  fetch requester read request.
REQ-006 f_addr  input  DWIDTH  fetch byte address.
REQ-007 f_gnt  output  1  fetch request accepted this cycle.
REQ-008 f_rvalid / f_err  output  1 each  fetch response valid / error flag.
REQ-009 f_rdata  output  DWIDTH  fetch response data.
REQ-010 d_req, d_addr, d_gnt, d_rvalid, d_err, d_rdata: debug/loader port, same widths and meaning as the fetch port.
REQ-011 mem_en  output  1  memory read enable.
REQ-012 mem_addr  output  DWIDTH  byte address to memory; memory indexes by mem_addr[DWIDTH-1:2].
REQ-013 mem_rdata  input  DWIDTH  memory registered read data, valid one cycle after mem_en.

Function
REQ-014 Gnt outputs SHALL be combinational from req, addr and arbitration state; at most one gnt high per cycle.
REQ-015 A requester with req high SHALL keep req and addr stable until its gnt is seen.
REQ-016 Fixed priority (default): d_req wins over f_req when both are high.
REQ-017 Legal request (addr[1:0]==0 and addr[DWIDTH-1:2] < MEMDEPTH): on grant, mem_en=1 and mem_addr=granted addr in the same cycle.
REQ-018 Illegal request (misaligned or out of range): granted normally, mem_en=0, response in next cycle with err=1 and rdata=0.
REQ-019 Response latency SHALL be exactly one cycle: grant in cycle N -> owner's rvalid=1 in cycle N+1, rdata=mem_rdata (legal) or 0 (illegal).
REQ-020 Response state SHALL be a registered owner tag (NONE/FETCH/DEBUG) plus err bit; rvalid pulses exactly one cycle per grant.
REQ-021 Back-to-back grants SHALL be supported every cycle, including alternating owners; no bubble inserted.
REQ-022 Non-owner rvalid SHALL be 0; rdata outputs for a non-valid port SHALL be 0.
REQ-023 When no req is high: mem_en=0, mem_addr=0, no gnt.

Reset
REQ-024 Reset high at a clock edge SHALL clear owner tag to NONE, err to 0, and the arbitration pointer to "fetch last served".
REQ-025 While reset is high: all gnt, rvalid, err, mem_en SHALL be 0; rdata and mem_addr SHALL be 0.
REQ-026 Reset asserted in the cycle after a grant SHALL suppress that grant's response; it is never delivered.

Configuration
REQ-027 Macro IMEM_ARB_RR_EN defined: two-way round-robin; on conflict, grant goes to the port not granted most recently; pointer updates on every grant.
REQ-028 IMEM_ARB_RR_EN undefined: fixed priority per REQ-016; pointer logic absent.

Verification
REQ-029 Reset then f_req=1, f_addr=0x8 -> f_gnt=1, mem_en=1, mem_addr=0x8; next cycle f_rvalid=1, f_rdata=mem word 2, f_err=0.
REQ-030 f_req and d_req high for 4 cycles, addrs 0x0/0x4 -> default: d_gnt 4 cycles, f_gnt 0; with IMEM_ARB_RR_EN: grants D,F,D,F.
REQ-031 d_req, d_addr=0x6 -> d_gnt=1, mem_en=0; next cycle d_rvalid=1, d_err=1, d_rdata=0.
REQ-032 f_req, f_addr=0x1000 (MEMDEPTH=1024) -> f_err=1, mem_en=0 next-cycle response.
REQ-033 Grant f_addr=0x4 in cycle N, reset high in N+1 -> f_rvalid=0 in N+1 and N+2; all outputs 0.
REQ-034 Alternating F 0x0, D 0x4, F 0x8 on consecutive cycles -> rvalid on F, D, F in cycles N+1..N+3 with words 0,1,2.
